// File: rtl/mem_txn_scheduler_if.sv
// Requester, transaction-engine and ack-bus signals of the memory transaction scheduler.
// slave = scheduler side, master = the environment driving requests and completions.
interface mem_txn_scheduler_if #(
  parameter int ADDR_W = 24
);
  logic [3:0]          in_req_valid;
  logic [3:0]          in_req_rw;
  logic [4*ADDR_W-1:0] in_req_addr;
  logic [3:0]          out_req_ready;
  logic                out_txn_start;
  logic                out_txn_rw;
  logic [ADDR_W-1:0]   out_txn_addr;
  logic [1:0]          out_txn_id;
  logic                in_txn_busy;
  logic                in_txn_done;
  logic                out_txn_abort;
  logic                out_ack_valid;
  logic [1:0]          out_ack_id;
  logic                out_ack_err;
  logic                in_ack_ready;
  logic                out_busy;

  modport slave (
    input  in_req_valid, in_req_rw, in_req_addr, in_txn_busy, in_txn_done, in_ack_ready,
    output out_req_ready, out_txn_start, out_txn_rw, out_txn_addr, out_txn_id,
           out_txn_abort, out_ack_valid, out_ack_id, out_ack_err, out_busy
  );

  modport master (
    output in_req_valid, in_req_rw, in_req_addr, in_txn_busy, in_txn_done, in_ack_ready,
    input  out_req_ready, out_txn_start, out_txn_rw, out_txn_addr, out_txn_id,
           out_txn_abort, out_ack_valid, out_ack_id, out_ack_err, out_busy
  );
endinterface

// File: rtl/mem_txn_scheduler.sv
// Round-robin scheduler sharing one memory transaction engine between four requesters,
// with a launch-to-done watchdog and a per-transaction ack carrying source ID and error.
module mem_txn_scheduler #(
  parameter int ADDR_W  = 24,
  parameter int TIMEOUT = 1000
) (
  input logic              clk,
  input logic              rst_n,
  mem_txn_scheduler_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, ACK} state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_t              state;
  logic [1:0]          rr_ptr;
  logic [1:0]          winner;
  logic                found;
  logic [15:0]         timer;
  logic                err;
  logic                abort;
  logic                txn_rw;
  logic [ADDR_W-1:0]   txn_addr;
  logic [1:0]          txn_id;

  // First pending requester at or after rr_ptr, wrapping modulo 4.
  always_comb begin
    winner = rr_ptr;
    found  = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (!found && bus.in_req_valid[rr_ptr + 2'(k)]) begin
        found  = 1'b1;
        winner = rr_ptr + 2'(k);
      end
    end
  end

  // Ready is gated by rst_n so every output reads 0 while reset is held.
  assign bus.out_req_ready = (rst_n && state == IDLE && found) ? (4'b0001 << winner) : 4'b0000;
  assign bus.out_txn_start = (state == LAUNCH) && !bus.in_txn_busy;
  assign bus.out_txn_rw    = txn_rw;
  assign bus.out_txn_addr  = txn_addr;
  assign bus.out_txn_id    = txn_id;
  assign bus.out_txn_abort = abort;
  assign bus.out_ack_valid = (state == ACK);
  assign bus.out_ack_id    = txn_id;
  assign bus.out_ack_err   = err;
  assign bus.out_busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr_ptr   <= 2'd0;
      timer    <= 16'd0;
      err      <= 1'b0;
      abort    <= 1'b0;
      txn_rw   <= 1'b0;
      txn_addr <= '0;
      txn_id   <= 2'd0;
    end else begin
      abort <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            txn_rw   <= bus.in_req_rw[winner];
            txn_addr <= bus.in_req_addr[int'(winner)*ADDR_W +: ADDR_W];
            txn_id   <= winner;
            state    <= LAUNCH;
          end
        end
        LAUNCH: begin
          if (!bus.in_txn_busy) begin
            timer <= 16'd0;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (timer != 16'hFFFF) timer <= timer + 16'd1;
          // Completion takes priority over a timeout in the same cycle.
          if (bus.in_txn_done) begin
            err   <= 1'b0;
            state <= ACK;
          end else if (timer == TMO_LAST) begin
            abort <= 1'b1;
            err   <= 1'b1;
            state <= ACK;
          end
        end
        ACK: begin
          if (bus.in_ack_ready) begin
            rr_ptr <= txn_id + 2'd1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_txn_scheduler.sv
// Scoreboard bench for mem_txn_scheduler: directed scenarios push expected events with
// their cycle numbers, a negedge monitor pops and compares every event the DUT presents.
module tb_mem_txn_scheduler;
  localparam int AW = 24;
  localparam int EV_ACC = 0, EV_START = 1, EV_ABORT = 2, EV_ACK = 3;

  typedef struct {
    int          kind;
    int          cyc;
    logic [1:0]  id;
    logic        rw;
    logic [23:0] addr;
    logic        err;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;
  exp_t sb[$];

  mem_txn_scheduler_if #(.ADDR_W(AW)) bus ();

  mem_txn_scheduler #(.ADDR_W(AW), .TIMEOUT(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kname(int k);
    case (k)
      EV_ACC:   return "accept";
      EV_START: return "start";
      EV_ABORT: return "abort";
      default:  return "ack";
    endcase
  endfunction

  task automatic push(int kind, int c, logic [1:0] id, logic rw, logic [23:0] addr, logic err);
    exp_t e;
    e.kind = kind; e.cyc = c; e.id = id; e.rw = rw; e.addr = addr; e.err = err;
    sb.push_back(e);
  endtask

  task automatic observe(int kind, logic [1:0] id, logic rw, logic [23:0] addr, logic err,
                         logic [3:0] rdy);
    exp_t e;
    bit   ok;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL unexpected_%s: cycle %0d id %0d err %0d, no event required",
               kname(kind), cyc, id, err);
      return;
    end
    e  = sb.pop_front();
    ok = (e.kind == kind) && (e.cyc == cyc);
    case (kind)
      EV_ACC:   ok = ok && (rdy == (4'b0001 << e.id));
      EV_START: ok = ok && (id == e.id) && (rw == e.rw) && (addr == e.addr);
      EV_ABORT: ok = ok && (id == e.id);
      default:  ok = ok && (id == e.id) && (err == e.err);
    endcase
    if (!ok) begin
      errors++;
      $display("FAIL %s: got cycle %0d id %0d rw %0d addr %h err %0d ready %b; required %s cycle %0d id %0d rw %0d addr %h err %0d",
               kname(kind), cyc, id, rw, addr, err, rdy, kname(e.kind), e.cyc, e.id, e.rw,
               e.addr, e.err);
    end
  endtask

  always @(negedge clk) begin
    if (|(bus.in_req_valid & bus.out_req_ready))
      observe(EV_ACC, 2'd0, 1'b0, 24'd0, 1'b0, bus.out_req_ready);
    if (bus.out_txn_start)
      observe(EV_START, bus.out_txn_id, bus.out_txn_rw, bus.out_txn_addr, 1'b0, 4'd0);
    if (bus.out_txn_abort)
      observe(EV_ABORT, bus.out_txn_id, 1'b0, 24'd0, 1'b0, 4'd0);
    if (bus.out_ack_valid && bus.in_ack_ready)
      observe(EV_ACK, bus.out_ack_id, 1'b0, 24'd0, bus.out_ack_err, 4'd0);
  end

  task automatic check(string nm, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_ready"},   32'(bus.out_req_ready), 32'd0);
    check({tag, "_txn"},     {29'd0, bus.out_txn_start, bus.out_txn_rw, bus.out_txn_abort}, 32'd0);
    check({tag, "_addr"},    32'(bus.out_txn_addr), 32'd0);
    check({tag, "_id"},      {28'd0, bus.out_txn_id, bus.out_ack_id}, 32'd0);
    check({tag, "_ack"},     {30'd0, bus.out_ack_valid, bus.out_ack_err}, 32'd0);
    check({tag, "_busy"},    32'(bus.out_busy), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, queue depth %0d", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int r;
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus.in_req_valid = 4'b1111;
    bus.in_req_rw    = 4'b0000;
    bus.in_req_addr  = '0;
    bus.in_txn_busy  = 1'b0;
    bus.in_txn_done  = 1'b0;
    bus.in_ack_ready = 1'b1;
    repeat (3) tick();
    check_all_zero("reset");
    bus.in_req_valid = 4'b0000;
    rst_n = 1'b1;
    tick();

    // Single read from requester 0, done five cycles after start.
    tick(); c0 = cyc;
    bus.in_req_valid = 4'b0001;
    bus.in_req_rw    = 4'b0001;
    bus.in_req_addr[0*AW +: AW] = 24'h123456;
    push(EV_ACC,   c0,     2'd0, 1'b0, 24'h0,      1'b0);
    push(EV_START, c0 + 1, 2'd0, 1'b1, 24'h123456, 1'b0);
    push(EV_ACK,   c0 + 7, 2'd0, 1'b0, 24'h0,      1'b0);
    tick(); bus.in_req_valid = 4'b0000;
    repeat (5) tick(); bus.in_txn_done = 1'b1;
    tick(); bus.in_txn_done = 1'b0;
    tick(); check("single_idle_busy", 32'(bus.out_busy), 32'd0);

    // Round-robin fairness from a fresh rr_ptr with all four requesting.
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    bus.in_req_rw = 4'b0101;
    for (int i = 0; i < 4; i++) bus.in_req_addr[i*AW +: AW] = 24'hA00000 | 24'(i);
    bus.in_txn_done = 1'b1;
    tick(); c0 = cyc;
    bus.in_req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      push(EV_ACC,   c0 + 4*k,     2'(k % 4), 1'b0,                 24'h0,                       1'b0);
      push(EV_START, c0 + 4*k + 1, 2'(k % 4), (k % 2 == 0) ? 1'b1 : 1'b0, 24'hA00000 | 24'(k % 4), 1'b0);
      push(EV_ACK,   c0 + 4*k + 3, 2'(k % 4), 1'b0,                 24'h0,                       1'b0);
    end
    repeat (17) tick(); bus.in_req_valid = 4'b0000;
    repeat (3) tick(); bus.in_txn_done = 1'b0;

    // Busy stall: requester 2 accepted while the engine is busy for seven cycles.
    tick(); c0 = cyc;
    bus.in_req_valid = 4'b0100;
    bus.in_req_rw    = 4'b0000;
    bus.in_req_addr[2*AW +: AW] = 24'hABCDEF;
    bus.in_txn_busy  = 1'b1;
    push(EV_ACC,   c0,     2'd2, 1'b0, 24'h0,      1'b0);
    push(EV_START, c0 + 7, 2'd2, 1'b0, 24'hABCDEF, 1'b0);
    push(EV_ACK,   c0 + 9, 2'd2, 1'b0, 24'h0,      1'b0);
    tick(); bus.in_req_valid = 4'b0000;
    repeat (2) tick();
    check("stall_addr",  32'(bus.out_txn_addr), 32'h00ABCDEF);
    check("stall_id",    32'(bus.out_txn_id),   32'd2);
    check("stall_start", 32'(bus.out_txn_start), 32'd0);
    repeat (4) tick(); bus.in_txn_busy = 1'b0;
    tick(); bus.in_txn_done = 1'b1;
    tick(); bus.in_txn_done = 1'b0;
    tick();

    // Timeout with rr_ptr wrapped to 3; ack held off, then a stray done in IDLE.
    tick(); c0 = cyc;
    bus.in_req_valid = 4'b1001;
    bus.in_req_rw    = 4'b1000;
    bus.in_req_addr[3*AW +: AW] = 24'h3C3C3C;
    bus.in_ack_ready = 1'b0;
    push(EV_ACC,   c0,      2'd3, 1'b0, 24'h0,      1'b0);
    push(EV_START, c0 + 1,  2'd3, 1'b1, 24'h3C3C3C, 1'b0);
    push(EV_ABORT, c0 + 10, 2'd3, 1'b0, 24'h0,      1'b0);
    push(EV_ACK,   c0 + 13, 2'd3, 1'b0, 24'h0,      1'b1);
    tick(); bus.in_req_valid = 4'b0000;
    repeat (10) tick();
    check("tmo_ack_hold", {29'd0, bus.out_ack_valid, bus.out_ack_err, bus.out_txn_rw}, 32'd7);
    check("tmo_ack_id",   32'(bus.out_ack_id),   32'd3);
    check("tmo_addr",     32'(bus.out_txn_addr), 32'h003C3C3C);
    repeat (2) tick(); bus.in_ack_ready = 1'b1;
    tick(); bus.in_txn_done = 1'b1;
    tick(); bus.in_txn_done = 1'b0;
    check("stray_done_busy", 32'(bus.out_busy), 32'd0);
    tick();

    // Done arrives on the same cycle the timer reaches TIMEOUT-1.
    tick(); c0 = cyc;
    bus.in_req_valid = 4'b0001;
    bus.in_req_rw    = 4'b0000;
    bus.in_req_addr[0*AW +: AW] = 24'h000ABC;
    push(EV_ACC,   c0,      2'd0, 1'b0, 24'h0,      1'b0);
    push(EV_START, c0 + 1,  2'd0, 1'b0, 24'h000ABC, 1'b0);
    push(EV_ACK,   c0 + 10, 2'd0, 1'b0, 24'h0,      1'b0);
    tick(); bus.in_req_valid = 4'b0000;
    repeat (8) tick(); bus.in_txn_done = 1'b1;
    tick(); bus.in_txn_done = 1'b0;
    tick();

    // Reset in the middle of WAIT drops the transaction; rr_ptr restarts at 0.
    tick(); c0 = cyc;
    bus.in_req_valid = 4'b0010;
    bus.in_req_rw    = 4'b0010;
    bus.in_req_addr[1*AW +: AW] = 24'h555AAA;
    push(EV_ACC,   c0,     2'd1, 1'b0, 24'h0,      1'b0);
    push(EV_START, c0 + 1, 2'd1, 1'b1, 24'h555AAA, 1'b0);
    tick(); bus.in_req_valid = 4'b0000;
    repeat (2) tick();
    bus.in_req_valid = 4'b1010;
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_rst");
    tick(); bus.in_txn_done = 1'b1;
    tick(); bus.in_txn_done = 1'b0;
    r = cyc;
    push(EV_ACC,   r,     2'd1, 1'b0, 24'h0,      1'b0);
    push(EV_START, r + 1, 2'd1, 1'b1, 24'h555AAA, 1'b0);
    push(EV_ACK,   r + 3, 2'd1, 1'b0, 24'h0,      1'b0);
    rst_n = 1'b1;
    tick(); bus.in_req_valid = 4'b0000;
    tick(); bus.in_txn_done = 1'b1;
    tick(); bus.in_txn_done = 1'b0;
    repeat (3) tick();
    check("final_busy", 32'(bus.out_busy), 32'd0);
    check("final_queue_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
